// File: rtl/stream_hdr_insert.sv
// stream_hdr_insert: prepends an HDR_W-bit header to each packet on a
// padbytes/last bus (byte 0 at MSB). Payload shifts toward the LSB by
// HDR_BYTES; a trailing beat is emitted when the last beat overflows.
// Build option: STREAM_HDR_INSERT_ZERO_FILL_EN forces the padbytes-covered
// bytes of every last beat to zero.
module stream_hdr_insert #(
  parameter int DATA_W          = 512,
  parameter int HDR_W           = 64,
  parameter int DATA_PADBYTES   = DATA_W/8,
  parameter int DATA_PADBYTES_W = $clog2(DATA_PADBYTES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       src_ins_hdr_val,
  input  logic [HDR_W-1:0]           src_ins_hdr,
  output logic                       ins_src_hdr_rdy,
  input  logic                       src_ins_data_val,
  input  logic [DATA_W-1:0]          src_ins_data,
  input  logic [DATA_PADBYTES_W-1:0] src_ins_data_padbytes,
  input  logic                       src_ins_data_last,
  output logic                       ins_src_data_rdy,
  output logic                       ins_dst_data_val,
  output logic [DATA_W-1:0]          ins_dst_data,
  output logic [DATA_PADBYTES_W-1:0] ins_dst_data_padbytes,
  output logic                       ins_dst_data_last,
  input  logic                       dst_ins_data_rdy
);

  localparam int HDR_BYTES = HDR_W/8;
  localparam int USE_W     = DATA_W - HDR_W;
  localparam int USE_BYTES = USE_W/8;
  localparam int PW        = DATA_PADBYTES_W + 1;

  typedef enum logic [1:0] {HDR_WAIT, FIRST, BODY, EXTRA} state_t;

  state_t                     state;
  logic [HDR_W-1:0]           hdr_reg;
  logic [HDR_W-1:0]           carry_reg;
  logic [DATA_PADBYTES_W-1:0] pad_reg;

  logic [PW-1:0]              p_ext;
  logic                       spill;
  logic                       in_fire;
  logic [DATA_W-1:0]          dst_data;

  // Padbytes math is one bit wider so p+USE_BYTES cannot wrap.
  assign p_ext   = {1'b0, src_ins_data_padbytes};
  // Last beat has fewer pad bytes than the shift pushes out: needs EXTRA.
  assign spill   = (p_ext < PW'(HDR_BYTES));
  assign in_fire = src_ins_data_val && ins_src_data_rdy;

  // State and side registers: header capture, low-bit carry, spill padding.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HDR_WAIT;
      hdr_reg   <= '0;
      carry_reg <= '0;
      pad_reg   <= '0;
    end else begin
      case (state)
        HDR_WAIT: if (src_ins_hdr_val) begin
          hdr_reg <= src_ins_hdr;
          state   <= FIRST;
        end
        FIRST, BODY: if (in_fire) begin
          carry_reg <= src_ins_data[HDR_W-1:0];
          if (!src_ins_data_last) begin
            state <= BODY;
          end else if (!spill) begin
            state <= HDR_WAIT;
          end else begin
            pad_reg <= DATA_PADBYTES_W'(p_ext + PW'(USE_BYTES));
            state   <= EXTRA;
          end
        end
        EXTRA: if (dst_ins_data_rdy) state <= HDR_WAIT;
        default: state <= HDR_WAIT;
      endcase
    end
  end

  // Zero-latency output datapath; everything is held low while in reset so
  // a mid-packet reset never leaks a partial beat downstream.
  always_comb begin
    ins_src_hdr_rdy       = 1'b0;
    ins_src_data_rdy      = 1'b0;
    ins_dst_data_val      = 1'b0;
    dst_data              = '0;
    ins_dst_data_last     = 1'b0;
    ins_dst_data_padbytes = '0;
    if (!rst) begin
      case (state)
        HDR_WAIT: ins_src_hdr_rdy = 1'b1;
        FIRST, BODY: begin
          dst_data         = {(state == FIRST) ? hdr_reg : carry_reg,
                              src_ins_data[DATA_W-1 -: USE_W]};
          ins_dst_data_val = src_ins_data_val;
          ins_src_data_rdy = dst_ins_data_rdy;
          if (src_ins_data_last && !spill) begin
            ins_dst_data_last     = 1'b1;
            ins_dst_data_padbytes = DATA_PADBYTES_W'(p_ext - PW'(HDR_BYTES));
          end
        end
        EXTRA: begin
          dst_data              = {carry_reg, {USE_W{1'b0}}};
          ins_dst_data_val      = 1'b1;
          ins_dst_data_last     = 1'b1;
          ins_dst_data_padbytes = pad_reg;
        end
        default: ;
      endcase
    end
  end

`ifdef STREAM_HDR_INSERT_ZERO_FILL_EN
  // Padbytes is 0 on non-last beats, so the mask only bites on last beats.
  assign ins_dst_data = dst_data & ({DATA_W{1'b1}} << {ins_dst_data_padbytes, 3'b000});
`else
  assign ins_dst_data = dst_data;
`endif

endmodule

// File: tb/tb_stream_hdr_insert.sv
// Directed bench for stream_hdr_insert (DATA_W=512, HDR_W=64).
module tb_stream_hdr_insert;
  localparam int DW = 512;
  localparam int HW = 64;
  localparam int PBW = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           hdr_val = 1'b0;
  logic [HW-1:0]  hdr = '0;
  logic           hdr_rdy;
  logic           din_val = 1'b0;
  logic [DW-1:0]  din = '0;
  logic [PBW-1:0] din_pad = '0;
  logic           din_last = 1'b0;
  logic           din_rdy;
  logic           dout_val;
  logic [DW-1:0]  dout;
  logic [PBW-1:0] dout_pad;
  logic           dout_last;
  logic           dst_rdy = 1'b1;

  int errs = 0;
  int n_chk = 0;
  int cyc = 0;
  bit tog_en = 1'b0;

  stream_hdr_insert #(.DATA_W(DW), .HDR_W(HW)) dut (
    .clk(clk), .rst(rst),
    .src_ins_hdr_val(hdr_val), .src_ins_hdr(hdr), .ins_src_hdr_rdy(hdr_rdy),
    .src_ins_data_val(din_val), .src_ins_data(din),
    .src_ins_data_padbytes(din_pad), .src_ins_data_last(din_last),
    .ins_src_data_rdy(din_rdy),
    .ins_dst_data_val(dout_val), .ins_dst_data(dout),
    .ins_dst_data_padbytes(dout_pad), .ins_dst_data_last(dout_last),
    .dst_ins_data_rdy(dst_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Byte i (MSB first) = s+i; the low p bytes are 0xFF pad.
  function automatic logic [DW-1:0] pat(input logic [7:0] s, input int p);
    logic [DW-1:0] v;
    for (int i = 0; i < DW/8; i++)
      v[DW-1-8*i -: 8] = (i >= DW/8 - p) ? 8'hFF : 8'(s + i);
    return v;
  endfunction

  function automatic logic [DW-1:0] vmask(input logic [PBW-1:0] p);
    logic [DW-1:0] ones;
    ones = '1;
    return ones << (p * 8);
  endfunction

  task automatic cmp_data(input string tag, input logic [DW-1:0] exp, input logic [PBW-1:0] ep);
`ifdef STREAM_HDR_INSERT_ZERO_FILL_EN
    chk(tag, dout, exp & vmask(ep));
`else
    chk(tag, dout & vmask(ep), exp & vmask(ep));
`endif
  endtask

  // Header cycle: output must be idle, header accepted.
  task automatic do_hdr(input logic [HW-1:0] h, input string tag);
    hdr_val = 1'b1; hdr = h; dst_rdy = 1'b1;
    @(negedge clk);
    chk({tag, ".hdr_rdy"}, DW'(hdr_rdy), DW'(1));
    chk({tag, ".idle"}, DW'(dout_val), DW'(0));
    @(posedge clk); #1;
    hdr_val = 1'b0; cyc++;
  endtask

  // One payload beat, held until it fires (dst_rdy toggles when tog_en).
  task automatic do_beat(input logic [DW-1:0] d, input logic [PBW-1:0] p, input logic l,
                         input logic [DW-1:0] exp, input logic [PBW-1:0] ep, input logic el,
                         input string tag);
    bit fired = 1'b0;
    din_val = 1'b1; din = d; din_pad = p; din_last = l;
    for (int k = 0; k < 8 && !fired; k++) begin
      dst_rdy = tog_en ? ~cyc[0] : 1'b1;
      @(negedge clk);
      chk({tag, ".rdy"}, DW'(din_rdy), DW'(dst_rdy));
      chk({tag, ".val"}, DW'(dout_val), DW'(1));
      chk({tag, ".hdr_rdy"}, DW'(hdr_rdy), DW'(0));
      cmp_data({tag, ".data"}, exp, ep);
      chk({tag, ".last"}, DW'(dout_last), DW'(el));
      chk({tag, ".pad"}, DW'(dout_pad), DW'(ep));
      fired = dst_rdy;
      @(posedge clk); #1;
      cyc++;
    end
    if (!fired) chk({tag, ".timeout"}, DW'(0), DW'(1));
    din_val = 1'b0; din_last = 1'b0; din_pad = '0;
  endtask

  // Trailing overflow beat: valid regardless of payload, payload not ready.
  task automatic do_extra(input logic [DW-1:0] exp, input logic [PBW-1:0] ep, input string tag);
    bit fired = 1'b0;
    for (int k = 0; k < 8 && !fired; k++) begin
      dst_rdy = tog_en ? ~cyc[0] : 1'b1;
      @(negedge clk);
      chk({tag, ".val"}, DW'(dout_val), DW'(1));
      chk({tag, ".rdy"}, DW'(din_rdy), DW'(0));
      cmp_data({tag, ".data"}, exp, ep);
      chk({tag, ".last"}, DW'(dout_last), DW'(1));
      chk({tag, ".pad"}, DW'(dout_pad), DW'(ep));
      fired = dst_rdy;
      @(posedge clk); #1;
      cyc++;
    end
    if (!fired) chk({tag, ".timeout"}, DW'(0), DW'(1));
  endtask

  initial begin
    logic [HW-1:0] h1, h2, h3;
    logic [DW-1:0] a, b, c, e;
    logic [DW-1:0] r2;
    h1 = 64'h1122334455667788;
    h2 = 64'hCAFEF00DDEADBEEF;
    h3 = 64'h0102030405060708;

    // Reset: hold with a valid payload present to prove outputs are gated.
    din_val = 1'b1; din = pat(8'h10, 0); din_last = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.val", DW'(dout_val), DW'(0));
    chk("rst.drdy", DW'(din_rdy), DW'(0));
    chk("rst.last", DW'(dout_last), DW'(0));
    chk("rst.pad", DW'(dout_pad), DW'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst.hdr_rdy", DW'(hdr_rdy), DW'(1));
    chk("post_rst.val", DW'(dout_val), DW'(0));
    chk("post_rst.drdy", DW'(din_rdy), DW'(0));
    @(posedge clk); #1;
    din_val = 1'b0; din_last = 1'b0;

    // T1: single beat p=20 -> one beat, pad 12 (input pad bytes are 0xFF).
    a = pat(8'h20, 20);
    e = {h1, a[DW-1:HW]};
    do_hdr(h1, "t1");
    do_beat(a, 6'd20, 1'b1, e, 6'd12, 1'b1, "t1.b0");
    @(negedge clk);
    chk("t1.after.val", DW'(dout_val), DW'(0));
    chk("t1.after.hdr_rdy", DW'(hdr_rdy), DW'(1));
    @(posedge clk); #1;

    // T2: single beat p=3 -> spill into EXTRA with pad 3+56=59; stall once.
    a = pat(8'h40, 3);
    do_hdr(h1, "t2");
    do_beat(a, 6'd3, 1'b1, {h1, a[DW-1:HW]}, 6'd0, 1'b0, "t2.b0");
    dst_rdy = 1'b0;
    @(negedge clk);
    chk("t2.stall.val", DW'(dout_val), DW'(1));
    chk("t2.stall.pad", DW'(dout_pad), DW'(59));
    @(posedge clk); #1;
    e = '0; e[DW-1 -: HW] = a[HW-1:0];
    do_extra(e, 6'd59, "t2.x");

    // T3: three beats, last p=8 exactly HDR_BYTES -> no EXTRA, pad 0.
    a = pat(8'h01, 0); b = pat(8'h81, 0); c = pat(8'hC1, 8);
    do_hdr(h2, "t3");
    do_beat(a, 6'd0, 1'b0, {h2, a[DW-1:HW]}, 6'd0, 1'b0, "t3.b0");
    do_beat(b, 6'd0, 1'b0, {a[HW-1:0], b[DW-1:HW]}, 6'd0, 1'b0, "t3.b1");
    do_beat(c, 6'd8, 1'b1, {b[HW-1:0], c[DW-1:HW]}, 6'd0, 1'b1, "t3.b2");
    @(negedge clk);
    chk("t3.noextra.val", DW'(dout_val), DW'(0));
    chk("t3.noextra.hdr_rdy", DW'(hdr_rdy), DW'(1));
    @(posedge clk); #1;

    // T4: back-to-back packets with dst_rdy toggling 1010.
    tog_en = 1'b1; cyc = 0;
    a = pat(8'h11, 0); b = pat(8'h51, 30);
    do_hdr(h3, "t4p0");
    do_beat(a, 6'd0, 1'b0, {h3, a[DW-1:HW]}, 6'd0, 1'b0, "t4p0.b0");
    do_beat(b, 6'd30, 1'b1, {a[HW-1:0], b[DW-1:HW]}, 6'd22, 1'b1, "t4p0.b1");
    a = pat(8'h91, 0); b = pat(8'hA1, 5);
    do_hdr(h2, "t4p1");
    do_beat(a, 6'd0, 1'b0, {h2, a[DW-1:HW]}, 6'd0, 1'b0, "t4p1.b0");
    do_beat(b, 6'd5, 1'b1, {a[HW-1:0], b[DW-1:HW]}, 6'd0, 1'b0, "t4p1.b1");
    e = '0; e[DW-1 -: HW] = b[HW-1:0];
    do_extra(e, 6'd61, "t4p1.x");
    tog_en = 1'b0;

    // T5: reset after beat 2 of a 4-beat packet; stray header is ignored.
    a = pat(8'h05, 0); b = pat(8'h45, 0);
    do_hdr(h1, "t5");
    hdr_val = 1'b1; hdr = h3;
    do_beat(a, 6'd0, 1'b0, {h1, a[DW-1:HW]}, 6'd0, 1'b0, "t5.b0");
    do_beat(b, 6'd0, 1'b0, {a[HW-1:0], b[DW-1:HW]}, 6'd0, 1'b0, "t5.b1");
    hdr_val = 1'b0;
    din_val = 1'b1; din = pat(8'h85, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("t5.inrst.val", DW'(dout_val), DW'(0));
    @(posedge clk); #1;
    rst = 1'b0; din_val = 1'b0;
    @(negedge clk);
    chk("t5.post.val", DW'(dout_val), DW'(0));
    chk("t5.post.hdr_rdy", DW'(hdr_rdy), DW'(1));
    chk("t5.post.drdy", DW'(din_rdy), DW'(0));
    @(posedge clk); #1;
    r2 = pat(8'hE0, 20);
    do_hdr(h2, "t5n");
    do_beat(r2, 6'd20, 1'b1, {h2, r2[DW-1:HW]}, 6'd12, 1'b1, "t5n.b0");

    $display("Result: errors=%0d of %0d checks", errs, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
